safety_mem_port_arbiter: RTL

// - Shares one OBI-style memory port between the core data port (P0) and shadow port (P1).
// - Sits between the core wrapper and the island memory bank.
// - Round-robin arbitration, in-order response routing through an owner FIFO, outstanding-transaction limit.

---
 rtl/safety_mem_port_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/safety_mem_port_arbiter.sv
// safety_mem_port_arbiter
// Shares one OBI-style memory port between the core data port (P0) and the
// shadow port (P1). Round-robin selection, a request hold while the memory
// stalls, in-order response routing through an owner FIFO and a limit on
// accepted-but-unanswered transactions.
//
// Ports
//   clk_i, rst_i                    clock, synchronous active-high reset
//   p{0,1}_req/we/be/addr/wdata_i   requester side request
//   p{0,1}_gnt_o                    request accepted this cycle
//   p{0,1}_rvalid/rdata/err_o       requester side response
//   mem_req/we/be/addr/wdata_o      request to memory (combinational)
//   mem_gnt/rvalid/rdata/err_i      memory handshake and response
//   protocol_err_o                  sticky: response seen with nothing outstanding
//
// Optional feature macro: SAFETY_ARB_PERF_CNT_EN
//   Adds saturating 32-bit counters p0_gnt_cnt_o, p1_gnt_cnt_o, contention_cnt_o.
module safety_mem_port_arbiter #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   p0_req_i,
  output logic                   p0_gnt_o,
  input  logic                   p0_we_i,
  input  logic [DataWidth/8-1:0] p0_be_i,
  input  logic [AddrWidth-1:0]   p0_addr_i,
  input  logic [DataWidth-1:0]   p0_wdata_i,
  output logic                   p0_rvalid_o,
  output logic [DataWidth-1:0]   p0_rdata_o,
  output logic                   p0_err_o,
  input  logic                   p1_req_i,
  output logic                   p1_gnt_o,
  input  logic                   p1_we_i,
  input  logic [DataWidth/8-1:0] p1_be_i,
  input  logic [AddrWidth-1:0]   p1_addr_i,
  input  logic [DataWidth-1:0]   p1_wdata_i,
  output logic                   p1_rvalid_o,
  output logic [DataWidth-1:0]   p1_rdata_o,
  output logic                   p1_err_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  input  logic                   mem_err_i,
`ifdef SAFETY_ARB_PERF_CNT_EN
  output logic [31:0]            p0_gnt_cnt_o,
  output logic [31:0]            p1_gnt_cnt_o,
  output logic [31:0]            contention_cnt_o,
`endif
  output logic                   protocol_err_o
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  logic                      rr_q;          // port granted last; 1 after reset so P0 wins first
  logic                      hold_q;
  logic                      hold_sel_q;
  logic [MaxOutstanding-1:0] owner_q;
  logic [PtrWidth-1:0]       wr_ptr_q;
  logic [PtrWidth-1:0]       rd_ptr_q;
  logic [CntWidth-1:0]       count_q;
  logic                      protocol_err_q;

  logic sel;
  logic sel_valid;
  logic sel_req;
  logic fifo_full;
  logic fifo_empty;
  logic handshake;
  logic pop;
  logic head_owner;

  // Port selection: a stalled request keeps its port, otherwise round-robin
  always_comb begin
    sel_valid = 1'b0;
    sel       = 1'b0;
    if (hold_q) begin
      sel_valid = 1'b1;
      sel       = hold_sel_q;
    end else if (p0_req_i && p1_req_i) begin
      sel_valid = 1'b1;
      sel       = ~rr_q;
    end else if (p0_req_i) begin
      sel_valid = 1'b1;
      sel       = 1'b0;
    end else if (p1_req_i) begin
      sel_valid = 1'b1;
      sel       = 1'b1;
    end
  end

  assign fifo_full  = (count_q == CntWidth'(MaxOutstanding));
  assign fifo_empty = (count_q == '0);
  assign sel_req    = sel ? p1_req_i : p0_req_i;
  // A same-cycle pop does not free a slot, keeping rvalid out of the grant path
  assign mem_req_o  = sel_valid & sel_req & ~fifo_full;
  assign handshake  = mem_req_o & mem_gnt_i;
  assign p0_gnt_o   = handshake & ~sel;
  assign p1_gnt_o   = handshake & sel;

  // Request payload mux
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (sel_valid) begin
      if (sel) begin
        mem_we_o    = p1_we_i;
        mem_be_o    = p1_be_i;
        mem_addr_o  = p1_addr_i;
        mem_wdata_o = p1_wdata_i;
      end else begin
        mem_we_o    = p0_we_i;
        mem_be_o    = p0_be_i;
        mem_addr_o  = p0_addr_i;
        mem_wdata_o = p0_wdata_i;
      end
    end
  end

  // Response routing to the owner at the FIFO head
  assign pop         = mem_rvalid_i & ~fifo_empty;
  assign head_owner  = owner_q[rd_ptr_q];
  assign p0_rvalid_o = pop & ~head_owner;
  assign p1_rvalid_o = pop & head_owner;
  assign p0_err_o    = pop & ~head_owner & mem_err_i;
  assign p1_err_o    = pop & head_owner & mem_err_i;
  assign p0_rdata_o  = mem_rdata_i;
  assign p1_rdata_o  = mem_rdata_i;

  assign protocol_err_o = protocol_err_q;

  // Arbitration state, owner FIFO and sticky protocol error
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q           <= 1'b1;
      hold_q         <= 1'b0;
      hold_sel_q     <= 1'b0;
      owner_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      hold_q     <= mem_req_o & ~mem_gnt_i;
      hold_sel_q <= sel;
      if (handshake) begin
        rr_q              <= sel;
        owner_q[wr_ptr_q] <= sel;
        wr_ptr_q          <= (wr_ptr_q == PtrWidth'(MaxOutstanding - 1)) ? '0
                                                                         : wr_ptr_q + PtrWidth'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrWidth'(MaxOutstanding - 1)) ? '0
                                                               : rd_ptr_q + PtrWidth'(1);
      end
      if (handshake && !pop) begin
        count_q <= count_q + CntWidth'(1);
      end else if (!handshake && pop) begin
        count_q <= count_q - CntWidth'(1);
      end
      if (mem_rvalid_i && fifo_empty) begin
        protocol_err_q <= 1'b1;
      end
    end
  end

`ifdef SAFETY_ARB_PERF_CNT_EN
  logic contention;
  assign contention = p0_req_i & p1_req_i & ~(p0_gnt_o & p1_gnt_o);

  // Saturating performance counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p0_gnt_cnt_o     <= '0;
      p1_gnt_cnt_o     <= '0;
      contention_cnt_o <= '0;
    end else begin
      if (p0_gnt_o && (p0_gnt_cnt_o != '1)) begin
        p0_gnt_cnt_o <= p0_gnt_cnt_o + 32'd1;
      end
      if (p1_gnt_o && (p1_gnt_cnt_o != '1)) begin
        p1_gnt_cnt_o <= p1_gnt_cnt_o + 32'd1;
      end
      if (contention && (contention_cnt_o != '1)) begin
        contention_cnt_o <= contention_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
